// File: rtl/ssb_symbol_scheduler.sv
// ssb_symbol_scheduler
// Frames the time-domain sample stream of one SS/PBCH block into OFDM symbols.
// For each symbol it drops the cyclic prefix and forwards FFT_LEN samples to the
// FFT demodulator. It also reports symbol position, busy and done status downstream.
`timescale 1ns/1ps

module ssb_symbol_scheduler #(
    parameter int IN_DW       = 32,
    parameter int FFT_LEN     = 256,
    parameter int CP_LEN      = 18,
    parameter int MAX_SYMBOLS = 4,
    localparam int NUM_W      = $clog2(MAX_SYMBOLS + 1),
    localparam int IDX_W      = (MAX_SYMBOLS > 1) ? $clog2(MAX_SYMBOLS) : 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_symbols_i,
    output logic [IN_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    output logic             SSB_start_o,
    output logic             symbol_start_o,
    output logic [IDX_W-1:0] symbol_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             start_ignored_o
);

    localparam int CP_W  = $clog2(CP_LEN + 1);
    localparam int FWD_W = $clog2(FFT_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_SKIP_CP,
        S_FWD
    } state_t;

    // The sample that starts a run is CP sample 0. With a one-sample prefix it
    // is also the last CP sample, so forwarding begins with the next sample.
    localparam state_t          FIRST_STATE = (CP_LEN == 1) ? S_FWD : S_SKIP_CP;
    localparam logic [CP_W-1:0]  FIRST_CP   = (CP_LEN == 1) ? CP_W'(0) : CP_W'(1);
    localparam logic [CP_W-1:0]  CP_LAST    = CP_W'(CP_LEN - 1);
    localparam logic [FWD_W-1:0] FWD_LAST   = FWD_W'(FFT_LEN - 1);
    localparam logic [NUM_W-1:0] MAX_SYM    = NUM_W'(MAX_SYMBOLS);

    state_t             state_q, state_d;
    logic [CP_W-1:0]    cp_cnt_q, cp_cnt_d;
    logic [FWD_W-1:0]   fwd_cnt_q, fwd_cnt_d;
    logic [IDX_W-1:0]   sym_idx_q, sym_idx_d;
    logic [NUM_W-1:0]   n_sym_q, n_sym_d;

    logic [IN_DW-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               ssb_start_q, ssb_start_d;
    logic               sym_start_q, sym_start_d;
    logic [IDX_W-1:0]   idx_out_q, idx_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_ign_q, start_ign_d;

    logic               last_sym;
    logic [NUM_W-1:0]   n_sym_clamped;

    assign last_sym      = ((NUM_W'(sym_idx_q) + NUM_W'(1)) == n_sym_q);
    assign n_sym_clamped = (num_symbols_i > MAX_SYM) ? MAX_SYM : num_symbols_i;

    // Next-state, counter and registered-output logic for the framing FSM.
    always_comb begin
        state_d     = state_q;
        cp_cnt_d    = cp_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        sym_idx_d   = sym_idx_q;
        n_sym_d     = n_sym_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        ssb_start_d = 1'b0;
        sym_start_d = 1'b0;
        idx_out_d   = idx_out_q;
        done_d      = 1'b0;
        start_ign_d = start_i && ((state_q != S_IDLE) || (num_symbols_i == '0));

        case (state_q)
            S_IDLE: begin
                idx_out_d = '0;
                if (start_i && (num_symbols_i != '0)) begin
                    n_sym_d   = n_sym_clamped;
                    sym_idx_d = '0;
                    cp_cnt_d  = '0;
                    fwd_cnt_d = '0;
                    if (s_axis_in_tvalid) begin
                        state_d  = FIRST_STATE;
                        cp_cnt_d = FIRST_CP;
                    end else begin
                        state_d = S_WAIT_FIRST;
                    end
                end
            end

            S_WAIT_FIRST: begin
                if (s_axis_in_tvalid) begin
                    state_d  = FIRST_STATE;
                    cp_cnt_d = FIRST_CP;
                end
            end

            S_SKIP_CP: begin
                if (s_axis_in_tvalid) begin
                    if (cp_cnt_q == CP_LAST) begin
                        state_d   = S_FWD;
                        cp_cnt_d  = '0;
                        fwd_cnt_d = '0;
                    end else begin
                        cp_cnt_d = cp_cnt_q + CP_W'(1);
                    end
                end
            end

            S_FWD: begin
                if (s_axis_in_tvalid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = s_axis_in_tdata;
                    sym_start_d = (fwd_cnt_q == '0);
                    ssb_start_d = (fwd_cnt_q == '0) && (sym_idx_q == '0);
                    idx_out_d   = sym_idx_q;
                    if (fwd_cnt_q == FWD_LAST) begin
                        fwd_cnt_d = '0;
                        if (last_sym) begin
                            done_d    = 1'b1;
                            state_d   = S_IDLE;
                            sym_idx_d = '0;
                        end else begin
                            sym_idx_d = sym_idx_q + IDX_W'(1);
                            state_d   = S_SKIP_CP;
                            cp_cnt_d  = '0;
                        end
                    end else begin
                        fwd_cnt_d = fwd_cnt_q + FWD_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and all outputs are registered; reset abandons any run.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cp_cnt_q    <= '0;
            fwd_cnt_q   <= '0;
            sym_idx_q   <= '0;
            n_sym_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ssb_start_q <= 1'b0;
            sym_start_q <= 1'b0;
            idx_out_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_ign_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cp_cnt_q    <= cp_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
            sym_idx_q   <= sym_idx_d;
            n_sym_q     <= n_sym_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ssb_start_q <= ssb_start_d;
            sym_start_q <= sym_start_d;
            idx_out_q   <= idx_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_ign_q <= start_ign_d;
        end
    end

    assign m_axis_out_tdata  = out_data_q;
    assign m_axis_out_tvalid = out_valid_q;
    assign SSB_start_o       = ssb_start_q;
    assign symbol_start_o    = sym_start_q;
    assign symbol_idx_o      = idx_out_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign start_ignored_o   = start_ign_q;

endmodule

// File: tb/tb_ssb_symbol_scheduler.sv
// Bench for ssb_symbol_scheduler with FFT_LEN=8, CP_LEN=2, MAX_SYMBOLS=4.
// Stimulus pushes hand-derived expected outputs into a queue; a monitor pops
// and compares them whenever the DUT presents a forwarded sample.
`timescale 1ns/1ps

module tb_ssb_symbol_scheduler;

    localparam int IN_DW   = 32;
    localparam int FFT_LEN = 8;
    localparam int CP_LEN  = 2;
    localparam int MAX_SYM = 4;
    localparam int SYM_LEN = CP_LEN + FFT_LEN;

    typedef struct packed {
        logic [31:0] data;
        logic        sym_start;
        logic        ssb;
        logic [1:0]  idx;
        logic        done;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [IN_DW-1:0] s_data;
    logic             s_valid;
    logic             start;
    logic [2:0]       num_sym;
    logic [IN_DW-1:0] m_axis_out_tdata;
    logic             m_axis_out_tvalid;
    logic             SSB_start_o;
    logic             symbol_start_o;
    logic [1:0]       symbol_idx_o;
    logic             busy_o;
    logic             done_o;
    logic             start_ignored_o;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   out_cnt    = 0;
    int   done_cnt   = 0;
    logic ign_pending = 1'b0;

    ssb_symbol_scheduler #(
        .IN_DW(IN_DW), .FFT_LEN(FFT_LEN), .CP_LEN(CP_LEN), .MAX_SYMBOLS(MAX_SYM)
    ) dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .s_axis_in_tdata   (s_data),
        .s_axis_in_tvalid  (s_valid),
        .start_i           (start),
        .num_symbols_i     (num_sym),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .SSB_start_o       (SSB_start_o),
        .symbol_start_o    (symbol_start_o),
        .symbol_idx_o      (symbol_idx_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .start_ignored_o   (start_ignored_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tvalid"}, 32'(m_axis_out_tvalid), 32'h0);
        checkOutput({tag, "_tdata"}, m_axis_out_tdata, 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'h0);
        checkOutput({tag, "_done"}, 32'(done_o), 32'h0);
        checkOutput({tag, "_idx"}, 32'(symbol_idx_o), 32'h0);
        checkOutput({tag, "_pulses"}, {29'h0, SSB_start_o, symbol_start_o, start_ignored_o}, 32'h0);
    endtask

    // One input cycle: checks the start_ignored response to the previous cycle,
    // then drives new inputs on the falling edge.
    task automatic driveCycle(input logic v, input logic [31:0] d, input logic st,
                              input int ns, input logic exp_ign);
        @(negedge clk);
        checkOutput("start_ignored", 32'(start_ignored_o), 32'(ign_pending));
        s_valid     = v;
        s_data      = d;
        start       = st;
        num_sym     = 3'(ns);
        ign_pending = exp_ign;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) driveCycle(1'b0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    // Issues one run: sample k carries base+k; CP positions 0..1 of each symbol
    // are dropped, positions 2..9 are forwarded. Optional pre-start idle gap,
    // tvalid toggling, a rejected mid-run start and an early stop.
    task automatic applyStimulus(input int nsym_in, input int n_exp, input int base,
                                 input bit toggle, input int pre_idle,
                                 input int inject_at, input int stop_at);
        int   last_k;
        int   drives;
        exp_t e;
        last_k = n_exp * SYM_LEN - 1;
        if (stop_at >= 0 && stop_at < last_k) last_k = stop_at;
        drives = 0;
        if (pre_idle > 0) begin
            driveCycle(1'b0, 32'h0, 1'b1, nsym_in, 1'b0);
            drives++;
            for (int i = 0; i < pre_idle; i++) begin
                driveCycle(1'b0, 32'h0, 1'b0, 0, 1'b0);
                drives++;
                if (drives == 2) checkOutput("busy_after_start", 32'(busy_o), 32'h1);
            end
        end
        for (int k = 0; k <= last_k; k++) begin
            if ((k % SYM_LEN) >= CP_LEN) begin
                e.data      = 32'(base + k);
                e.sym_start = ((k % SYM_LEN) == CP_LEN);
                e.ssb       = (k == CP_LEN);
                e.idx       = 2'(k / SYM_LEN);
                e.done      = (k == n_exp * SYM_LEN - 1);
                exp_q.push_back(e);
            end
            driveCycle(1'b1, 32'(base + k), ((k == 0) && (pre_idle == 0)) || (k == inject_at),
                       nsym_in, (k == inject_at));
            drives++;
            if (drives == 2) checkOutput("busy_after_start", 32'(busy_o), 32'h1);
            if (toggle && k != last_k) begin
                driveCycle(1'b0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
                drives++;
                if (drives == 2) checkOutput("busy_after_start", 32'(busy_o), 32'h1);
            end
        end
    endtask

    // Monitor: compares each forwarded sample against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_axis_out_tvalid === 1'b1) begin
                out_cnt++;
                if (done_o === 1'b1) done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got data %0h expected no output",
                             m_axis_out_tdata);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", m_axis_out_tdata, e.data);
                    checkOutput("symbol_start", 32'(symbol_start_o), 32'(e.sym_start));
                    checkOutput("ssb_start", 32'(SSB_start_o), 32'(e.ssb));
                    checkOutput("symbol_idx", 32'(symbol_idx_o), 32'(e.idx));
                    checkOutput("done", 32'(done_o), 32'(e.done));
                    checkOutput("busy_with_output", 32'(busy_o), 32'(!e.done));
                end
            end else begin
                checkOutput("pulse_without_valid", {29'h0, done_o, SSB_start_o, symbol_start_o}, 32'h0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed sequence.
    initial begin
        int cnt0;
        int done0;
        reset_n = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        start   = 1'b0;
        num_sym = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        #2 reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] continuous run, 4 symbols");
        cnt0 = out_cnt; done0 = done_cnt;
        applyStimulus(4, 4, 0, 1'b0, 0, -1, -1);
        idleCycles(3);
        checkOutput("run_a_outputs", 32'(out_cnt - cnt0), 32'd32);
        checkOutput("run_a_done", 32'(done_cnt - done0), 32'd1);
        checkOutput("run_a_idle_busy", 32'(busy_o), 32'h0);

        $display("[TB] toggling tvalid run");
        cnt0 = out_cnt;
        applyStimulus(4, 4, 0, 1'b1, 0, -1, -1);
        idleCycles(3);
        checkOutput("run_b_outputs", 32'(out_cnt - cnt0), 32'd32);

        $display("[TB] start with num_symbols=0");
        driveCycle(1'b0, 32'h0, 1'b1, 0, 1'b1);
        driveCycle(1'b0, 32'h0, 1'b0, 0, 1'b0);
        checkOutput("rejected_busy", 32'(busy_o), 32'h0);
        for (int i = 0; i < 3; i++) driveCycle(1'b1, 32'h77, 1'b0, 0, 1'b0);
        idleCycles(2);
        checkOutput("rejected_busy_later", 32'(busy_o), 32'h0);

        $display("[TB] delayed first sample, num_symbols=7 clamps to 4");
        cnt0 = out_cnt;
        applyStimulus(7, 4, 100, 1'b0, 3, -1, -1);
        idleCycles(3);
        checkOutput("run_c_outputs", 32'(out_cnt - cnt0), 32'd32);

        $display("[TB] ignored start mid-run then back-to-back run");
        cnt0 = out_cnt; done0 = done_cnt;
        applyStimulus(4, 4, 200, 1'b0, 0, 25, -1);
        applyStimulus(2, 2, 300, 1'b0, 0, -1, -1);
        idleCycles(3);
        checkOutput("run_de_outputs", 32'(out_cnt - cnt0), 32'd48);
        checkOutput("run_de_done", 32'(done_cnt - done0), 32'd2);

        $display("[TB] reset during symbol 1");
        cnt0 = out_cnt;
        applyStimulus(4, 4, 400, 1'b0, 0, -1, 14);
        @(negedge clk);
        s_valid = 1'b0;
        start   = 1'b0;
        checkOutput("valid_before_reset", 32'(m_axis_out_tvalid), 32'h1);
        done0 = done_cnt;
        #2 reset_n = 1'b0;
        #1 checkAllZero("async_reset");
        idleCycles(3);
        #2 reset_n = 1'b1;
        idleCycles(4);
        checkOutput("no_done_after_reset", 32'(done_cnt), 32'(done0));
        checkOutput("run_f_outputs", 32'(out_cnt - cnt0), 32'd11);
        checkOutput("queue_empty_after_reset", 32'(exp_q.size()), 32'h0);

        $display("[TB] clean run after reset");
        cnt0 = out_cnt; done0 = done_cnt;
        applyStimulus(4, 4, 500, 1'b0, 0, -1, -1);
        idleCycles(4);
        checkOutput("run_g_outputs", 32'(out_cnt - cnt0), 32'd32);
        checkOutput("run_g_done", 32'(done_cnt - done0), 32'd1);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssb_symbol_scheduler.md
# ssb_symbol_scheduler

Controller that sequences the FFT demodulator for one SS/PBCH block. After a start event from the PSS/timing stage, it frames the incoming time-domain sample stream into OFDM symbols. For each symbol it strips the cyclic prefix and forwards exactly FFT_LEN samples. It drives the FFT demodulator's input stream and SSB start strobe, and reports symbol position, busy and completion status to the downstream SSS/PBCH logic.

## Interface
- IN_DW, 32, sample width (I/Q packed)
- FFT_LEN, 256, forwarded samples per symbol (≥ 2)
- CP_LEN, 18, cyclic-prefix samples discarded per symbol (≥ 1)
- MAX_SYMBOLS, 4, maximum symbols per run
- clk_i  in  1  clock
- reset_ni  in  1  reset, asynchronous, active-low
- s_axis_in_tdata  in  IN_DW  time-domain sample
- s_axis_in_tvalid  in  1  sample valid (no backpressure)
- start_i  in  1  pulse: the current valid sample, or else the next one, is the first CP sample of symbol 0
- num_symbols_i  in  $clog2(MAX_SYMBOLS+1)  symbols to process, sampled only on an accepted start
- m_axis_out_tdata  out  IN_DW  forwarded sample
- m_axis_out_tvalid  out  1  forwarded sample valid
- SSB_start_o  out  1  one-cycle pulse with the first forwarded sample of symbol 0
- symbol_start_o  out  1  one-cycle pulse with the first forwarded sample of every symbol
- symbol_idx_o  out  $clog2(MAX_SYMBOLS)  index of the symbol being forwarded
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse with the last forwarded sample of the run
- start_ignored_o  out  1  one-cycle pulse when start_i is rejected

## Operation
- States: IDLE, WAIT_FIRST, SKIP_CP, FWD.
- IDLE with start_i=1:
  - num_symbols_i=0: reject the start and pulse start_ignored_o.
  - Otherwise latch n_sym = min(num_symbols_i, MAX_SYMBOLS).
  - If tvalid=1 in the same cycle, that sample is CP sample 0; go to SKIP_CP with cp_cnt=1 (or straight to FWD if CP_LEN=1).
  - If tvalid=0, go to WAIT_FIRST.
- WAIT_FIRST: the first valid sample is CP sample 0; continue as above.
- SKIP_CP: each valid sample increments cp_cnt and is discarded. The CP_LEN-th valid sample moves the FSM to FWD with fwd_cnt=0.
- FWD: each valid sample is forwarded and fwd_cnt increments.
  - fwd_cnt=0 sample: assert symbol_start_o. Also assert SSB_start_o when symbol_idx=0.
  - fwd_cnt=FFT_LEN-1 sample: if symbol_idx=n_sym-1, assert done_o and go to IDLE. Otherwise increment symbol_idx and go to SKIP_CP with cp_cnt=0.
- Counters advance only on tvalid=1. Gaps in tvalid stall the FSM; no output valid is generated during a gap.
- start_i while busy (any non-IDLE state) is ignored and pulses start_ignored_o. The run continues unchanged.
- busy_o is high in every non-IDLE state, and in the cycle after the done_o sample's acceptance it reads 0.
- symbol_idx_o holds its value between symbols. It returns to 0 on entry to IDLE.
- Reset (asynchronous, any state) forces IDLE. All counters and outputs go to 0, including m_axis_out_tdata. A run in progress is abandoned without done_o.

## Timing
- All outputs are registered.
- A sample accepted in cycle n (tvalid=1, to be forwarded) appears on m_axis_out_* in cycle n+1, with its symbol_start_o, SSB_start_o, symbol_idx_o and done_o.
- busy_o rises in cycle n+1 after the accepted start in cycle n. It falls in the same cycle that done_o is high.
- start_ignored_o is high in cycle n+1 for a rejected start in cycle n.
- A start in the cycle right after done_o (IDLE) is accepted. Back-to-back runs have no dead cycle.
- Samples per symbol: CP_LEN + FFT_LEN valid inputs. A full run consumes n_sym·(CP_LEN+FFT_LEN) valid inputs.
- Counter widths: cp_cnt holds CP_LEN and fwd_cnt holds FFT_LEN-1 without wrap. Both reset to 0 at each symbol boundary.

## Test plan
- Continuous tvalid: FFT_LEN=8, CP_LEN=2, num_symbols_i=4, input data = sample index 0..39, start_i with sample 0.
  - Outputs: 32 valids carrying 2–9, 12–19, 22–29, 32–39.
  - symbol_start_o with 2, 12, 22, 32; SSB_start_o only with 2.
  - symbol_idx_o = 0, 1, 2, 3.
  - done_o with 39; busy_o low the following cycle.
- Same stimulus with tvalid toggling every other cycle: identical output data sequence and pulses. m_axis_out_tvalid follows input valids with 1-cycle delay; no extra valids.
- start_i with tvalid=0, then 3 idle cycles: the first valid sample is treated as CP sample 0.
  - num_symbols_i=0: no busy_o, start_ignored_o pulse.
  - num_symbols_i=7: clamps to MAX_SYMBOLS=4, so 32 outputs.
- start_i pulsed during symbol 2: start_ignored_o pulses and the run output is unchanged. A new start in the cycle after done_o begins a new run with zero gap.
- Reset asserted mid-FWD of symbol 1: all outputs are 0 asynchronously and done_o never fires. After release, a new start produces a clean 4-symbol run.
